// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with a small transmit FIFO.
// Frame format: start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
module uart_tx_cfg #(
    parameter int CLKS_PER_BIT = 5,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          frame,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = 4;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [PW:0]   DEPTH    = (PW + 1)'(FIFO_DEPTH);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx_cfg: CLKS_PER_BIT must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_cfg: FIFO_DEPTH must be a power of 2, at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [IW-1:0]        idx, idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 par, par_n;
    logic                 frame_n;
    logic                 bit_end;
    logic                 push, pop;
    logic                 fifo_nonempty;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [DATA_BITS-1:0] head;
    logic [PW-1:0]        wr_ptr, rd_ptr;

    assign in_ready      = (fifo_count < DEPTH) && !rst;
    assign push          = in_valid && in_ready;
    assign fifo_nonempty = (fifo_count != '0);
    assign head          = mem[rd_ptr];
    assign bit_end       = (cnt == CNT_LAST);
    assign busy          = (state != S_IDLE);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shreg_n = shreg;
        par_n   = par;
        frame_n = frame;
        pop     = 1'b0;
        if (state != S_IDLE) begin
            cnt_n = bit_end ? '0 : cnt + 1'b1;
        end
        case (state)
            S_IDLE: begin
                frame_n = 1'b1;
                cnt_n   = '0;
                if (fifo_nonempty) begin
                    pop     = 1'b1;
                    shreg_n = head;
                    par_n   = (^head) ^ (PARITY == 1);
                    idx_n   = '0;
                    frame_n = 1'b0;
                    state_n = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    idx_n   = '0;
                    frame_n = shreg[0];
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (idx == IW'(DATA_BITS - 1)) begin
                        idx_n = '0;
                        if (PARITY != 0) begin
                            frame_n = par;
                            state_n = S_PARITY;
                        end else begin
                            frame_n = 1'b1;
                            state_n = S_STOP;
                        end
                    end else begin
                        idx_n   = idx + 1'b1;
                        shreg_n = shreg >> 1;
                        frame_n = shreg[1];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    idx_n   = '0;
                    frame_n = 1'b1;
                    state_n = S_STOP;
                end
            end
            S_STOP: begin
                // Back-to-back frames: the next character starts with no idle gap.
                if (bit_end) begin
                    if (idx == IW'(STOP_BITS - 1)) begin
                        idx_n = '0;
                        if (fifo_nonempty) begin
                            pop     = 1'b1;
                            shreg_n = head;
                            par_n   = (^head) ^ (PARITY == 1);
                            frame_n = 1'b0;
                            state_n = S_START;
                        end else begin
                            frame_n = 1'b1;
                            state_n = S_IDLE;
                        end
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end
            default: begin
                frame_n = 1'b1;
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            par        <= 1'b0;
            frame      <= 1'b1;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shreg <= shreg_n;
            par   <= par_n;
            frame <= frame_n;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage is never reset; entries are only read once written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: default, even/odd parity and 7-bit/2-stop instances.
module tb_uart_tx_cfg;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid_v   [4];
    logic       in_ready_v   [4];
    logic       frame_v      [4];
    logic       busy_v       [4];
    logic [2:0] fifo_count_v [4];
    logic [7:0] txChars      [10];
    int         cntLog       [0:1023];
    logic       rdyLog       [0:1023];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    uart_tx_cfg dut0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid_v[0]),
        .in_ready(in_ready_v[0]), .frame(frame_v[0]), .busy(busy_v[0]),
        .fifo_count(fifo_count_v[0])
    );
    uart_tx_cfg #(.PARITY(2)) dut1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid_v[1]),
        .in_ready(in_ready_v[1]), .frame(frame_v[1]), .busy(busy_v[1]),
        .fifo_count(fifo_count_v[1])
    );
    uart_tx_cfg #(.PARITY(1)) dut2 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid_v[2]),
        .in_ready(in_ready_v[2]), .frame(frame_v[2]), .busy(busy_v[2]),
        .fifo_count(fifo_count_v[2])
    );
    uart_tx_cfg #(.CLKS_PER_BIT(3), .DATA_BITS(7), .STOP_BITS(2)) dut3 (
        .clk(clk), .rst(rst), .in_data(in_data[6:0]), .in_valid(in_valid_v[3]),
        .in_ready(in_ready_v[3]), .frame(frame_v[3]), .busy(busy_v[3]),
        .fifo_count(fifo_count_v[3])
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Per-cycle waveform from a hand-written bit list (bit 0 is the first bit on the line).
    function automatic logic [63:0] expand(input logic [15:0] bits, input int nbits, input int cpb);
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < nbits * cpb; k++) begin
            v[k] = bits[k / cpb];
        end
        return v;
    endfunction

    function automatic logic expBit(input logic [7:0] c, input int pos);
        if (pos == 0) return 1'b0;
        if (pos <= 8) return c[pos - 1];
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push one character into an idle instance and check the one-cycle pop latency.
    task automatic applyStimulus(input int inst, input logic [7:0] data);
        in_data          = data;
        in_valid_v[inst] = 1'b1;
        step();
        in_valid_v[inst] = 1'b0;
        checkOutput($sformatf("push count %0d", inst), fifo_count_v[inst], 1);
        checkOutput($sformatf("push frame %0d", inst), frame_v[inst], 1);
        step();
        checkOutput($sformatf("pop frame %0d", inst), frame_v[inst], 0);
        checkOutput($sformatf("pop busy %0d", inst), busy_v[inst], 1);
        checkOutput($sformatf("pop count %0d", inst), fifo_count_v[inst], 0);
    endtask

    task automatic captureFrame(input int inst, input int len, input logic [63:0] expWave, input string tag);
        logic [63:0] cap;
        int          nb;
        cap = '0;
        nb  = 0;
        for (int k = 0; k < len; k++) begin
            cap[k] = frame_v[inst];
            if (busy_v[inst] === 1'b1) nb++;
            step();
        end
        checkOutput({tag, " wave"}, cap, expWave);
        checkOutput({tag, " busy cycles"}, nb, len);
        checkOutput({tag, " idle busy"}, busy_v[inst], 0);
        checkOutput({tag, " idle frame"}, frame_v[inst], 1);
    endtask

    // Streams n characters through dut0; pushes of index >= holdFrom wait until edge holdUntil.
    task automatic streamTest(input int n, input int holdFrom, input int holdUntil, input string tag);
        int   idx;
        int   mism;
        int   last;
        int   k;
        logic pushing;
        idx  = 0;
        mism = 0;
        last = 2 + 50 * n;
        for (int e = 1; e <= last; e++) begin
            in_data       = (idx < n) ? txChars[idx] : 8'h00;
            in_valid_v[0] = (idx < n) && !(idx >= holdFrom && e < holdUntil);
            pushing       = in_valid_v[0] && in_ready_v[0];
            step();
            if (pushing) idx++;
            cntLog[e] = int'(fifo_count_v[0]);
            rdyLog[e] = in_ready_v[0];
            if (e >= 2 && e < last) begin
                k = e - 2;
                if (frame_v[0] !== expBit(txChars[k / 50], (k % 50) / 5)) mism++;
                if (busy_v[0] !== 1'b1) mism++;
            end
        end
        in_valid_v[0] = 1'b0;
        checkOutput({tag, " pushed"}, idx, n);
        checkOutput({tag, " stream bits"}, mism, 0);
        checkOutput({tag, " end busy"}, busy_v[0], 0);
        checkOutput({tag, " end frame"}, frame_v[0], 1);
        checkOutput({tag, " end count"}, fifo_count_v[0], 0);
    endtask

    initial begin
        int viol;
        rst     = 1'b1;
        in_data = 8'h00;
        for (int i = 0; i < 4; i++) in_valid_v[i] = 1'b0;
        step();
        step();
        checkOutput("reset in_ready", in_ready_v[0], 0);
        checkOutput("reset frame", frame_v[0], 1);
        checkOutput("reset busy", busy_v[0], 0);
        checkOutput("reset count", fifo_count_v[0], 0);
        rst = 1'b0;
        #1;
        checkOutput("release in_ready", in_ready_v[0], 1);

        applyStimulus(0, 8'hA5);
        captureFrame(0, 50, expand(16'b1101001010, 10, 5), "a5");
        applyStimulus(1, 8'h07);
        captureFrame(1, 55, expand(16'b11000001110, 11, 5), "even");
        applyStimulus(2, 8'h07);
        captureFrame(2, 55, expand(16'b10000001110, 11, 5), "odd");
        applyStimulus(3, 8'h55);
        captureFrame(3, 30, expand(16'b1110101010, 10, 3), "7b2s");

        txChars = '{8'h3C, 8'hC3, 8'h01, 8'h80, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        streamTest(5, 99, 0, "burst5");
        checkOutput("burst5 count e1", cntLog[1], 1);
        checkOutput("burst5 count e2", cntLog[2], 1);
        checkOutput("burst5 count e3", cntLog[3], 2);
        checkOutput("burst5 count e4", cntLog[4], 3);
        checkOutput("burst5 count e5", cntLog[5], 4);
        checkOutput("burst5 ready e4", rdyLog[4], 1);
        checkOutput("burst5 ready e5", rdyLog[5], 0);
        checkOutput("burst5 count e52", cntLog[52], 3);

        txChars = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 8'h66, 8'h77, 8'h88, 8'h99, 8'hE7};
        streamTest(10, 3, 52, "wrap10");
        checkOutput("wrap10 count e51", cntLog[51], 2);
        checkOutput("wrap10 simul push pop", cntLog[52], 2);

        in_data       = 8'h00;
        in_valid_v[0] = 1'b1;
        step();
        in_data = 8'hAA;
        step();
        in_data = 8'h55;
        step();
        in_valid_v[0] = 1'b0;
        repeat (20) step();
        checkOutput("pre-reset data bit3", frame_v[0], 0);
        checkOutput("pre-reset count", fifo_count_v[0], 2);
        rst = 1'b1;
        step();
        checkOutput("abort frame", frame_v[0], 1);
        checkOutput("abort busy", busy_v[0], 0);
        checkOutput("abort count", fifo_count_v[0], 0);
        checkOutput("abort in_ready", in_ready_v[0], 0);
        rst = 1'b0;
        #1;
        checkOutput("abort release in_ready", in_ready_v[0], 1);
        viol = 0;
        for (int c = 0; c < 120; c++) begin
            step();
            if (frame_v[0] !== 1'b1 || busy_v[0] !== 1'b0) viol++;
        end
        checkOutput("abort no resume", viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
